// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and sizing for the cache block fill engine.
package cache_pkg;

   localparam int unsigned BLOCK_WORDS  = 8;
   localparam int unsigned OFFSET_W     = $clog2(BLOCK_WORDS);
   localparam int unsigned CNT_W        = OFFSET_W + 1;
   localparam int unsigned WORD_BYTES   = 2;
   localparam int unsigned WORD_W       = 16;
   localparam int unsigned ADDR_W       = 16;
   localparam int unsigned MEM_LATENCY  = 4;
   localparam int unsigned BLOCK_BYTE_W = $clog2(BLOCK_WORDS * WORD_BYTES);
   localparam int unsigned WORD_SHIFT   = $clog2(WORD_BYTES);

   typedef enum logic {IDLE, FILL} fill_state_t;

   // Byte address of word idx within the block at base; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]   base,
                                                   input logic [OFFSET_W-1:0] idx);
      return base + (ADDR_W'(idx) << WORD_SHIFT);
   endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Fill progress counter: enable, synchronous clear, asynchronous reset.
module fill_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches one block from memory and streams it into the data array.
// Optional critical-word-first ordering via `define CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm
   import cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                miss_detected,
   input  logic [ADDR_W-1:0]   miss_address,
   input  logic                memory_data_valid,
   input  logic [WORD_W-1:0]   memory_data,
   output logic                fsm_busy,
   output logic                mem_en,
   output logic [ADDR_W-1:0]   memory_address,
   output logic                write_data_array,
   output logic [OFFSET_W-1:0] data_offset,
   output logic [WORD_W-1:0]   fill_data,
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   output logic                critical_word_ready,
`endif
   output logic                write_tag_array
);

   fill_state_t         state;
   logic [ADDR_W-1:0]   base;
   logic [CNT_W-1:0]    issue_cnt;
   logic [CNT_W-1:0]    recv_cnt;
   logic [OFFSET_W-1:0] issue_idx;
   logic [OFFSET_W-1:0] recv_idx;
   logic                unused_ok;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   logic [OFFSET_W-1:0] crit;
`endif

   // Low address bits only select the word within the block.
   assign unused_ok = ^miss_address[BLOCK_BYTE_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         base  <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
         crit  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (miss_detected) begin
                  state <= FILL;
                  base  <= {miss_address[ADDR_W-1:BLOCK_BYTE_W], {BLOCK_BYTE_W{1'b0}}};
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                  crit  <= miss_address[BLOCK_BYTE_W-1:WORD_SHIFT];
`endif
               end
            end
            FILL: begin
               if (write_tag_array) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Requests stream out back-to-back; returned words are written as they arrive.
   always_comb begin
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      issue_idx = crit + issue_cnt[OFFSET_W-1:0];
      recv_idx  = crit + recv_cnt[OFFSET_W-1:0];
`else
      issue_idx = issue_cnt[OFFSET_W-1:0];
      recv_idx  = recv_cnt[OFFSET_W-1:0];
`endif
      fsm_busy         = (state == FILL);
      mem_en           = fsm_busy && (issue_cnt < CNT_W'(BLOCK_WORDS));
      memory_address   = mem_en ? word_addr(base, issue_idx) : '0;
      write_data_array = fsm_busy && memory_data_valid && (recv_cnt < issue_cnt);
      data_offset      = write_data_array ? recv_idx : '0;
      fill_data        = write_data_array ? memory_data : '0;
      write_tag_array  = write_data_array && (recv_cnt == CNT_W'(BLOCK_WORDS - 1));
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      critical_word_ready = write_data_array && (recv_cnt == '0);
`endif
   end

   fill_counter #(.W(CNT_W)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (mem_en),
      .clr   (write_tag_array),
      .count (issue_cnt)
   );

   fill_counter #(.W(CNT_W)) u_recv_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (write_data_array),
      .clr   (write_tag_array),
      .count (recv_cnt)
   );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm with a latency-programmable in-order memory model.
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = 16'h0;
   logic        memory_data_valid = 1'b0;
   logic [15:0] memory_data = 16'h0;
   logic        fsm_busy;
   logic        mem_en;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  data_offset;
   logic [15:0] fill_data;
   logic        write_tag_array;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   logic        critical_word_ready;
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   cache_fill_fsm dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .mem_en            (mem_en),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .data_offset       (data_offset),
      .fill_data         (fill_data),
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      .critical_word_ready (critical_word_ready),
`endif
      .write_tag_array   (write_tag_array)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [15:0] data;
   } resp_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // memory model
   resp_t       resp_q[$];
   int          last_due = 0;
   int          lat_min = 4;
   int          lat_max = 4;
   logic [15:0] mem_tag = 16'hA000;
   bit          spur_en = 1'b0;

   // behavioural reference state
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_issued = 0;
   int          m_written = 0;
   int          m_crit = 0;
   logic [15:0] m_base = 16'h0;

   // observation logs
   logic [15:0] addr_log[$];
   int          off_log[$];
   logic [15:0] dat_log[$];
   int          tag_off_log[$];
   int          tag_idx_log[$];
   int          tag_cyc_log[$];
   int          rise_log[$];
   int          crit_off_log[$];
   int          busy_cnt = 0;
   bit          busy_prev = 1'b0;

   function automatic int crit_of(input logic [15:0] a);
      return CWF ? ((int'(a) >> 1) & 7) : 0;
   endfunction

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return 16'(int'(mem_tag) + ((int'(a) >> 1) & 7));
   endfunction

   task automatic clear_logs();
      addr_log.delete(); off_log.delete(); dat_log.delete();
      tag_off_log.delete(); tag_idx_log.delete(); tag_cyc_log.delete();
      rise_log.delete(); crit_off_log.delete();
      busy_cnt = 0;
   endtask

   // One clock: advance model, drive memory, sample and compare, log, schedule responses.
   task automatic tick();
      logic        miss_e;
      logic [15:0] addr_e;
      bit          genuine;
      resp_t       r;
      bit          exp_busy, exp_mem_en, exp_write, exp_tag;
      logic [15:0] exp_addr, exp_fill;
      int          exp_off;
      int          lat;
      miss_e = miss_detected;
      addr_e = miss_address;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_busy = 0; m_done = 0; m_issued = 0; m_written = 0;
         resp_q.delete(); last_due = 0;
      end else if (m_busy && m_done) begin
         m_busy = 0; m_done = 0;
      end else if (!m_busy && miss_e) begin
         m_busy = 1; m_base = addr_e & 16'hFFF0; m_crit = crit_of(addr_e);
         m_issued = 0; m_written = 0;
      end
      #1;
      genuine = 0;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
         r = resp_q.pop_front();
         memory_data_valid = 1'b1; memory_data = r.data; genuine = 1;
      end else if (spur_en && !m_busy) begin
         memory_data_valid = 1'b1; memory_data = 16'($urandom);
      end else begin
         memory_data_valid = 1'b0; memory_data = 16'($urandom);
      end
      #1;
      exp_busy   = m_busy;
      exp_mem_en = m_busy && (m_issued < 8);
      exp_addr   = exp_mem_en ? 16'(int'(m_base) + 2 * ((m_crit + m_issued) % 8)) : 16'h0;
      exp_write  = m_busy && genuine && (m_written < m_issued);
      exp_off    = exp_write ? (m_crit + m_written) % 8 : 0;
      exp_fill   = exp_write ? memory_data : 16'h0;
      exp_tag    = exp_write && (m_written == 7);
      checks += 7;
      if (fsm_busy !== exp_busy) begin
         failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, fsm_busy, exp_busy);
      end
      if (mem_en !== exp_mem_en) begin
         failures++; $display("FAIL mem_en cyc=%0d got=%b exp=%b", cyc, mem_en, exp_mem_en);
      end
      if (memory_address !== exp_addr) begin
         failures++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, memory_address, exp_addr);
      end
      if (write_data_array !== exp_write) begin
         failures++; $display("FAIL wr_data cyc=%0d got=%b exp=%b", cyc, write_data_array, exp_write);
      end
      if (data_offset !== 3'(exp_off)) begin
         failures++; $display("FAIL offset cyc=%0d got=%0d exp=%0d", cyc, data_offset, exp_off);
      end
      if (fill_data !== exp_fill) begin
         failures++; $display("FAIL fill_data cyc=%0d got=%h exp=%h", cyc, fill_data, exp_fill);
      end
      if (write_tag_array !== exp_tag) begin
         failures++; $display("FAIL wr_tag cyc=%0d got=%b exp=%b", cyc, write_tag_array, exp_tag);
      end
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      checks++;
      if (critical_word_ready !== (exp_write && m_written == 0)) begin
         failures++; $display("FAIL crit_ready cyc=%0d got=%b", cyc, critical_word_ready);
      end
      if (critical_word_ready === 1'b1) crit_off_log.push_back(int'(data_offset));
`endif
      if (mem_en === 1'b1) addr_log.push_back(memory_address);
      if (write_data_array === 1'b1) begin
         off_log.push_back(int'(data_offset));
         dat_log.push_back(fill_data);
      end
      if (write_tag_array === 1'b1) begin
         tag_off_log.push_back(int'(data_offset));
         tag_idx_log.push_back(int'(off_log.size()) - 1);
         tag_cyc_log.push_back(cyc);
      end
      if (fsm_busy === 1'b1) busy_cnt++;
      if (fsm_busy === 1'b1 && !busy_prev) rise_log.push_back(cyc);
      busy_prev = (fsm_busy === 1'b1);
      if (mem_en === 1'b1) begin
         lat   = int'($urandom_range(lat_max, lat_min));
         r.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         r.data = mem_word(memory_address);
         last_due = r.due;
         resp_q.push_back(r);
      end
      if (exp_mem_en) m_issued++;
      if (exp_write) begin
         m_written++;
         if (exp_tag) m_done = 1;
      end
   endtask

   task automatic start_miss(input logic [15:0] a);
      miss_detected = 1'b1;
      miss_address  = a;
      tick();
      miss_detected = 1'b0;
      miss_address  = 16'($urandom);
   endtask

   task automatic run_until_idle(input int max_cyc);
      int n = 0;
      while (m_busy && n < max_cyc) begin
         tick();
         n++;
      end
      checks++;
      if (m_busy) begin
         failures++; $display("FAIL fill_timeout cyc=%0d issued=%0d written=%0d", cyc, m_issued, m_written);
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      memory_data_valid = 1'b1;
      #1;
      checks += 3;
      if (fsm_busy !== 1'b0 || mem_en !== 1'b0 || write_tag_array !== 1'b0) begin
         failures++; $display("FAIL reset_ctrl got busy=%b mem_en=%b tag=%b exp=0", fsm_busy, mem_en, write_tag_array);
      end
      if (memory_address !== 16'h0 || write_data_array !== 1'b0) begin
         failures++; $display("FAIL reset_addr got addr=%h wr=%b exp=0", memory_address, write_data_array);
      end
      if (data_offset !== 3'd0 || fill_data !== 16'h0) begin
         failures++; $display("FAIL reset_data got off=%0d data=%h exp=0", data_offset, fill_data);
      end
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_fill();
      int c;
      clear_logs();
      lat_min = 4; lat_max = 4; mem_tag = 16'hA000;
      c = crit_of(16'h1236);
      start_miss(16'h1236);
      run_until_idle(40);
      checks += 4;
      if (addr_log.size() != 8) begin
         failures++; $display("FAIL basic_req_count got=%0d exp=8", addr_log.size());
      end
      if (off_log.size() != 8) begin
         failures++; $display("FAIL basic_wr_count got=%0d exp=8", off_log.size());
      end
      if (tag_off_log.size() != 1 || tag_off_log[0] != (c + 7) % 8) begin
         failures++; $display("FAIL basic_tag got_n=%0d exp_n=1 exp_off=%0d", tag_off_log.size(), (c + 7) % 8);
      end
      if (busy_cnt != 12) begin
         failures++; $display("FAIL basic_busy_cycles got=%0d exp=12", busy_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         checks += 3;
         if (addr_log[i] !== 16'(16'h1230 + 2 * ((c + i) % 8))) begin
            failures++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, addr_log[i], 16'(16'h1230 + 2 * ((c + i) % 8)));
         end
         if (off_log[i] != (c + i) % 8) begin
            failures++; $display("FAIL basic_off[%0d] got=%0d exp=%0d", i, off_log[i], (c + i) % 8);
         end
         if (dat_log[i] !== 16'(16'hA000 + (c + i) % 8)) begin
            failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, dat_log[i], 16'(16'hA000 + (c + i) % 8));
         end
      end
   endtask

   task automatic test_variable_latency();
      logic [15:0] a;
      logic [15:0] b;
      int c;
      for (int k = 0; k < 3; k++) begin
         clear_logs();
         lat_min = 4; lat_max = 9; mem_tag = 16'($urandom);
         a = 16'($urandom); b = a & 16'hFFF0; c = crit_of(a);
         start_miss(a);
         run_until_idle(120);
         checks += 3;
         if (addr_log.size() != 8) begin
            failures++; $display("FAIL varlat_req_count got=%0d exp=8", addr_log.size());
         end
         if (off_log.size() != 8) begin
            failures++; $display("FAIL varlat_wr_count got=%0d exp=8", off_log.size());
         end
         if (tag_idx_log.size() != 1 || tag_idx_log[0] != 7) begin
            failures++; $display("FAIL varlat_tag got_n=%0d exp: one tag write with the 8th word", tag_idx_log.size());
         end
         for (int i = 0; i < 8; i++) begin
            checks += 2;
            if (off_log[i] != (c + i) % 8) begin
               failures++; $display("FAIL varlat_off[%0d] got=%0d exp=%0d", i, off_log[i], (c + i) % 8);
            end
            if (dat_log[i] !== mem_word(16'(int'(b) + 2 * ((c + i) % 8)))) begin
               failures++; $display("FAIL varlat_data[%0d] got=%h exp=%h", i, dat_log[i], mem_word(16'(int'(b) + 2 * ((c + i) % 8))));
            end
         end
      end
   endtask

   task automatic test_top_of_memory();
      int c;
      clear_logs();
      lat_min = 4; lat_max = 4; mem_tag = 16'h5000;
      c = crit_of(16'hFFFA);
      start_miss(16'hFFFA);
      run_until_idle(40);
      checks++;
      if (addr_log.size() != 8) begin
         failures++; $display("FAIL top_req_count got=%0d exp=8", addr_log.size());
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (addr_log[i] !== 16'(16'hFFF0 + 2 * ((c + i) % 8))) begin
            failures++; $display("FAIL top_addr[%0d] got=%h exp=%h", i, addr_log[i], 16'(16'hFFF0 + 2 * ((c + i) % 8)));
         end
      end
      clear_logs();
      spur_en = 1'b1;
      repeat (10) tick();
      spur_en = 1'b0;
      checks += 2;
      if (off_log.size() != 0) begin
         failures++; $display("FAIL idle_spurious_writes got=%0d exp=0", off_log.size());
      end
      if (busy_cnt != 0) begin
         failures++; $display("FAIL idle_spurious_busy got=%0d exp=0", busy_cnt);
      end
   endtask

   task automatic test_reset_mid_fill();
      int n = 0;
      clear_logs();
      lat_min = 4; lat_max = 4; mem_tag = 16'h3C00;
      start_miss(16'h2468);
      while (off_log.size() < 3 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (off_log.size() != 3) begin
         failures++; $display("FAIL midrst_reach got=%0d exp=3 writes", off_log.size());
      end
      rst = 1'b1;
      memory_data_valid = 1'b1;
      memory_data = 16'hBEEF;
      #1;
      checks += 3;
      if (fsm_busy !== 1'b0 || mem_en !== 1'b0 || write_tag_array !== 1'b0) begin
         failures++; $display("FAIL midrst_ctrl got busy=%b mem_en=%b tag=%b exp=0", fsm_busy, mem_en, write_tag_array);
      end
      if (write_data_array !== 1'b0 || fill_data !== 16'h0 || data_offset !== 3'd0 || memory_address !== 16'h0) begin
         failures++; $display("FAIL midrst_data got wr=%b data=%h off=%0d addr=%h exp=0", write_data_array, fill_data, data_offset, memory_address);
      end
      if (tag_off_log.size() != 0) begin
         failures++; $display("FAIL midrst_tag got=%0d exp=0", tag_off_log.size());
      end
      tick();
      rst = 1'b0;
      tick();
      clear_logs();
      start_miss(16'h0040);
      run_until_idle(40);
      checks += 2;
      if (off_log.size() != 8 || addr_log.size() != 8) begin
         failures++; $display("FAIL postrst_counts got wr=%0d req=%0d exp=8", off_log.size(), addr_log.size());
      end
      if (tag_off_log.size() != 1) begin
         failures++; $display("FAIL postrst_tag got=%0d exp=1", tag_off_log.size());
      end
      for (int i = 0; i < 8; i++) begin
         checks += 2;
         if (off_log[i] != i) begin
            failures++; $display("FAIL postrst_off[%0d] got=%0d exp=%0d", i, off_log[i], i);
         end
         if (addr_log[i] !== 16'(16'h0040 + 2 * i)) begin
            failures++; $display("FAIL postrst_addr[%0d] got=%h exp=%h", i, addr_log[i], 16'(16'h0040 + 2 * i));
         end
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int lat;
      clear_logs();
      lat = int'($urandom_range(9, 4));
      lat_min = lat; lat_max = lat; mem_tag = 16'($urandom);
      miss_detected = 1'b1;
      miss_address  = 16'($urandom);
      while (rise_log.size() < 2 && n < 200) begin
         tick();
         n++;
      end
      miss_detected = 1'b0;
      run_until_idle(60);
      checks += 4;
      if (rise_log.size() != 2) begin
         failures++; $display("FAIL b2b_fills got=%0d exp=2", rise_log.size());
      end
      if (tag_cyc_log.size() != 2) begin
         failures++; $display("FAIL b2b_tags got=%0d exp=2", tag_cyc_log.size());
      end
      if (rise_log[1] != tag_cyc_log[0] + 2) begin
         failures++; $display("FAIL b2b_restart got=%0d exp=%0d", rise_log[1], tag_cyc_log[0] + 2);
      end
      if (busy_cnt != 2 * (8 + lat) || addr_log.size() != 16) begin
         failures++; $display("FAIL b2b_busy got busy=%0d req=%0d exp busy=%0d req=16", busy_cnt, addr_log.size(), 2 * (8 + lat));
      end
   endtask

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   task automatic test_critical_word();
      logic [15:0] ea[8] = '{16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238};
      int          eo[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
      clear_logs();
      lat_min = 4; lat_max = 4; mem_tag = 16'hA000;
      start_miss(16'h123A);
      run_until_idle(40);
      checks++;
      if (crit_off_log.size() != 1 || crit_off_log[0] != 5) begin
         failures++; $display("FAIL cwf_ready got_n=%0d exp one pulse at offset 5", crit_off_log.size());
      end
      for (int i = 0; i < 8; i++) begin
         checks += 2;
         if (addr_log[i] !== ea[i]) begin
            failures++; $display("FAIL cwf_addr[%0d] got=%h exp=%h", i, addr_log[i], ea[i]);
         end
         if (off_log[i] != eo[i]) begin
            failures++; $display("FAIL cwf_off[%0d] got=%0d exp=%0d", i, off_log[i], eo[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_fill();
      test_variable_latency();
      test_top_of_memory();
      test_reset_mid_fill();
      test_back_to_back();
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      test_critical_word();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
